pw_lockout_ctrl: RTL and testbench
==================================

PW_LOCKOUT_CTRL -- requirements
Module: pw_lockout_ctrl

Interface
REQ-001 Parameter MAX_TRIES, default 3, wrong attempts before lockout; legal range 1..15.
REQ-002 Parameter LOCK_TICKS, default 30, lockout duration in tick pulses; legal range 1..255.
REQ-003 Parameter UNLOCK_TICKS, default 50, unlocked-window duration in tick pulses; legal range 1..255.
REQ-004 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 tick  in  1  one-cycle enable pulse from the clock divider, the time base for all countdowns.
REQ-007 correct  in  1  one-cycle pulse from the password FSM: combination accepted.
REQ-008 error  in  1  one-cycle pulse from the password FSM: combination rejected.
REQ-009 prog_req  in  1  one-shot pulse requesting code programming.
REQ-010 key_in  in  10  one-shot switch pulses, bit i = digit i.
REQ-011 fsm_en  out  1  high only when the password FSM is allowed to accept input.
REQ-012 fsm_clr  out  1  one-cycle synchronous clear to the password FSM.
REQ-013 code_we  out  1  one-cycle write strobe for a new stored code.
REQ-014 code_out  out  16  four 4-bit digit indices; digit 0 in [15:12].
REQ-015 status  out  2  state code: ARMED=0, UNLOCKED=1, LOCKED=2, PROG=3.
REQ-016 tries_left  out  4  remaining attempts.
REQ-017 remain  out  8  remaining ticks of the current timed state.

Function
REQ-018 All outputs SHALL be registered; responses appear one clk after the causing input.
REQ-019 fsm_en SHALL equal 1 in ARMED and 0 in every other state.
REQ-020 ARMED, correct: go to UNLOCKED, remain=UNLOCK_TICKS, tries_left=MAX_TRIES, fsm_clr pulse.
REQ-021 ARMED, error with tries_left>1: decrement tries_left, stay ARMED, fsm_clr pulse.
REQ-022 ARMED, error with tries_left==1: go to LOCKED, tries_left=0, remain=LOCK_TICKS, fsm_clr pulse.
REQ-023 correct and error in the same cycle SHALL be treated as error.
REQ-024 UNLOCKED/LOCKED: each tick decrements remain; the tick seen with remain==1 sets remain=0, goes to ARMED, pulses fsm_clr, and sets tries_left=MAX_TRIES.
REQ-025 remain SHALL never wrap below 0; tries_left SHALL never underflow.
REQ-026 LOCKED SHALL ignore correct, error, prog_req and key_in.
REQ-027 UNLOCKED, prog_req: go to PROG, digit counter=0, remain frozen.
REQ-028 prog_req and the expiring tick in the same cycle: prog_req SHALL win.
REQ-029 PROG: key_in with exactly one bit set shifts that bit index (0-9) into a 16-bit shadow register and increments the digit counter.
REQ-030 PROG: key_in with zero or more than one bit set SHALL be ignored.
REQ-031 PROG, 4th valid digit: code_out=shadow, code_we 1-cycle pulse, go to ARMED, fsm_clr pulse, tries_left=MAX_TRIES, remain=0.
REQ-032 PROG, prog_req: abort to ARMED; no code_we; code_out unchanged; shadow discarded.
REQ-033 PROG: tick, correct and error SHALL be ignored.
REQ-034 fsm_clr and code_we SHALL never exceed one cycle high.

Reset
REQ-035 rst SHALL force: status=ARMED, tries_left=MAX_TRIES, remain=0, code_out=16'h0123, fsm_en=1, fsm_clr=1 for the reset cycle, code_we=0, digit counter=0, shadow=0.
REQ-036 rst SHALL take priority over every other input in any state, including mid-programming.

Structure
REQ-037 A shared package pw_pkg SHALL hold the state encoding, DIGITS=4, and the digit width of 4.
REQ-038 One sub-module key_encode SHALL convert 10-bit one-hot to a 4-bit index plus a valid flag (valid only for exactly one bit set).

Verification
REQ-039 Reset, then correct pulse -> status=1, remain=50, tries_left=3, one fsm_clr pulse.
REQ-040 Three error pulses from ARMED -> tries_left 2,1,0; status=2; remain=30; fsm_en=0; after 30 ticks status=0 and tries_left=3.
REQ-041 UNLOCKED, prog_req, keys 4,0,9,2 (key_in=0x010,0x001,0x200,0x004) -> code_out=16'h4092, one code_we pulse, status=0.
REQ-042 PROG, key_in=0x011 then prog_req -> digit ignored, abort to status=0, no code_we, code_out unchanged.
REQ-043 correct and error in the same cycle with tries_left=1 -> status=2 (LOCKED).
REQ-044 rst asserted after 2 digits in PROG -> status=0, code_out=16'h0123, next PROG session needs 4 new digits.

Source files
------------

// File: rtl/pw_pkg.sv
// rtl/pw_pkg.sv - shared state encoding and code geometry for the lockout controller
package pw_pkg;

  localparam int DIGITS      = 4;
  localparam int DIGIT_W     = 4;
  localparam int CODE_W      = DIGITS * DIGIT_W;
  localparam int KEYS        = 10;
  localparam int DIGIT_CNT_W = $clog2(DIGITS);

  localparam logic [CODE_W-1:0] RESET_CODE = 16'h0123;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_PROG     = 2'd3
  } state_e;

endpackage

// File: rtl/pw_lockout_ctrl_if.sv
// rtl/pw_lockout_ctrl_if.sv - request pulses in, registered status and code out
interface pw_lockout_ctrl_if;
  import pw_pkg::*;

  logic                tick;
  logic                correct;
  logic                error;
  logic                prog_req;
  logic [KEYS-1:0]     key_in;
  logic                fsm_en;
  logic                fsm_clr;
  logic                code_we;
  logic [CODE_W-1:0]   code_out;
  logic [1:0]          status;
  logic [3:0]          tries_left;
  logic [7:0]          remain;

  modport master (
    output tick, correct, error, prog_req, key_in,
    input  fsm_en, fsm_clr, code_we, code_out, status, tries_left, remain
  );

  modport slave (
    input  tick, correct, error, prog_req, key_in,
    output fsm_en, fsm_clr, code_we, code_out, status, tries_left, remain
  );

endinterface

// File: rtl/key_encode.sv
// rtl/key_encode.sv - one-hot keypad vector to digit index, valid only for a single key
module key_encode
  import pw_pkg::*;
(
  input  logic [KEYS-1:0]    onehot_i,
  output logic [DIGIT_W-1:0] idx_o,
  output logic               valid_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (onehot_i[i]) idx_o = DIGIT_W'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign valid_o = (onehot_i != '0) &&
                   ((onehot_i & (onehot_i - {{(KEYS-1){1'b0}}, 1'b1})) == '0);

endmodule

// File: rtl/pw_lockout_ctrl.sv
// rtl/pw_lockout_ctrl.sv - attempt counting, timed lockout/unlock windows and code programming
module pw_lockout_ctrl
  import pw_pkg::*;
#(
  parameter int MAX_TRIES    = 3,
  parameter int LOCK_TICKS   = 30,
  parameter int UNLOCK_TICKS = 50
) (
  input logic              clk,
  input logic              rst,
  pw_lockout_ctrl_if.slave bus
);

  localparam logic [3:0] TRIES_INIT  = 4'(MAX_TRIES);
  localparam logic [7:0] LOCK_INIT   = 8'(LOCK_TICKS);
  localparam logic [7:0] UNLOCK_INIT = 8'(UNLOCK_TICKS);

  state_e                  state_q;
  logic [3:0]              tries_q;
  logic [7:0]              remain_q;
  logic                    fsm_en_q;
  logic                    fsm_clr_q;
  logic                    code_we_q;
  logic [CODE_W-1:0]       code_q;
  logic [CODE_W-1:0]       shadow_q;
  logic [DIGIT_CNT_W-1:0]  digit_q;

  logic [DIGIT_W-1:0]      key_idx;
  logic                    key_valid;
  logic [CODE_W-1:0]       shadow_d;
  logic                    last_digit;

  key_encode u_key_encode (
    .onehot_i (bus.key_in),
    .idx_o    (key_idx),
    .valid_o  (key_valid)
  );

  assign shadow_d   = {shadow_q[CODE_W-DIGIT_W-1:0], key_idx};
  assign last_digit = (digit_q == DIGIT_CNT_W'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ARMED;
      tries_q   <= TRIES_INIT;
      remain_q  <= '0;
      fsm_en_q  <= 1'b1;
      fsm_clr_q <= 1'b1;
      code_we_q <= 1'b0;
      code_q    <= RESET_CODE;
      shadow_q  <= '0;
      digit_q   <= '0;
    end else begin
      fsm_clr_q <= 1'b0;
      code_we_q <= 1'b0;
      unique case (state_q)
        ST_ARMED: begin
          // error wins over a simultaneous correct
          if (bus.error) begin
            fsm_clr_q <= 1'b1;
            if (tries_q > 4'd1) begin
              tries_q <= tries_q - 4'd1;
            end else begin
              tries_q  <= '0;
              state_q  <= ST_LOCKED;
              remain_q <= LOCK_INIT;
              fsm_en_q <= 1'b0;
            end
          end else if (bus.correct) begin
            fsm_clr_q <= 1'b1;
            tries_q   <= TRIES_INIT;
            state_q   <= ST_UNLOCKED;
            remain_q  <= UNLOCK_INIT;
            fsm_en_q  <= 1'b0;
          end
        end
        ST_UNLOCKED: begin
          if (bus.prog_req) begin
            state_q  <= ST_PROG;
            digit_q  <= '0;
            shadow_q <= '0;
          end else if (bus.tick) begin
            if (remain_q <= 8'd1) begin
              remain_q  <= '0;
              state_q   <= ST_ARMED;
              tries_q   <= TRIES_INIT;
              fsm_en_q  <= 1'b1;
              fsm_clr_q <= 1'b1;
            end else begin
              remain_q <= remain_q - 8'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (bus.tick) begin
            if (remain_q <= 8'd1) begin
              remain_q  <= '0;
              state_q   <= ST_ARMED;
              tries_q   <= TRIES_INIT;
              fsm_en_q  <= 1'b1;
              fsm_clr_q <= 1'b1;
            end else begin
              remain_q <= remain_q - 8'd1;
            end
          end
        end
        ST_PROG: begin
          if (bus.prog_req) begin
            state_q   <= ST_ARMED;
            tries_q   <= TRIES_INIT;
            remain_q  <= '0;
            fsm_en_q  <= 1'b1;
            fsm_clr_q <= 1'b1;
            shadow_q  <= '0;
            digit_q   <= '0;
          end else if (key_valid) begin
            if (last_digit) begin
              code_q    <= shadow_d;
              code_we_q <= 1'b1;
              state_q   <= ST_ARMED;
              tries_q   <= TRIES_INIT;
              remain_q  <= '0;
              fsm_en_q  <= 1'b1;
              fsm_clr_q <= 1'b1;
              shadow_q  <= '0;
              digit_q   <= '0;
            end else begin
              shadow_q <= shadow_d;
              digit_q  <= digit_q + DIGIT_CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.fsm_en     = fsm_en_q;
  assign bus.fsm_clr    = fsm_clr_q;
  assign bus.code_we    = code_we_q;
  assign bus.code_out   = code_q;
  assign bus.status     = state_q;
  assign bus.tries_left = tries_q;
  assign bus.remain     = remain_q;

endmodule

// File: tb/tb_pw_lockout_ctrl.sv
// tb/tb_pw_lockout_ctrl.sv - directed vectors with a queued scoreboard checked by a separate monitor
module tb_pw_lockout_ctrl;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  pw_lockout_ctrl_if bus ();

  pw_lockout_ctrl #(
    .MAX_TRIES    (3),
    .LOCK_TICKS   (30),
    .UNLOCK_TICKS (50)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // -1 in any expected field means "not constrained"
  typedef struct {
    string name;
    int    due;
    int    st, tr, rm, en, clr, we, code;
  } exp_t;

  exp_t q[$];
  exp_t m;

  function automatic bit ok(int want, int got);
    return (want < 0) || (want == got);
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      m = q.pop_front();
      n_chk++;
      if (m.due == cyc &&
          ok(m.st,   int'(bus.status))  && ok(m.tr, int'(bus.tries_left)) &&
          ok(m.rm,   int'(bus.remain))  && ok(m.en, int'(bus.fsm_en)) &&
          ok(m.clr,  int'(bus.fsm_clr)) && ok(m.we, int'(bus.code_we)) &&
          ok(m.code, int'(bus.code_out))) begin
        n_pass++;
      end else begin
        $display("FAIL %s cyc=%0d: got st=%0d tr=%0d rm=%0d en=%0d clr=%0d we=%0d code=%h, want st=%0d tr=%0d rm=%0d en=%0d clr=%0d we=%0d code=%h (due %0d)",
                 m.name, cyc, bus.status, bus.tries_left, bus.remain, bus.fsm_en, bus.fsm_clr,
                 bus.code_we, bus.code_out, m.st, m.tr, m.rm, m.en, m.clr, m.we, m.code, m.due);
      end
    end
  end

  task automatic step(input string name, input int r, input int tk, input int c, input int er,
                      input int pr, input int k, input int st, input int tr, input int rm,
                      input int en, input int clr, input int we, input int code);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = (r != 0);
    bus.tick     = (tk != 0);
    bus.correct  = (c != 0);
    bus.error    = (er != 0);
    bus.prog_req = (pr != 0);
    bus.key_in   = 10'(k);
    e.name = name; e.due = cyc + 1;
    e.st = st; e.tr = tr; e.rm = rm; e.en = en; e.clr = clr; e.we = we; e.code = code;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    bus.tick = 1'b0; bus.correct = 1'b0; bus.error = 1'b0; bus.prog_req = 1'b0; bus.key_in = '0;

    //    name          rst tk c er pr key     st tr rm  en clr we code
    step("reset",        1, 0, 0, 0, 0, 'h000, 0, 3, 0,  1, 1,  0, 'h0123);
    step("idle0",        0, 0, 0, 0, 0, 'h000, 0, 3, 0,  1, 0,  0, 'h0123);
    step("correct",      0, 0, 1, 0, 0, 'h000, 1, 3, 50, 0, 1,  0, 'h0123);
    step("unl_idle",     0, 0, 0, 0, 0, 'h000, 1, 3, 50, 0, 0,  0, 'h0123);
    step("unl_tick",     0, 1, 0, 0, 0, 'h000, 1, 3, 49, 0, 0,  0, 'h0123);
    step("unl_ignore",   0, 0, 1, 1, 0, 'h000, 1, 3, 49, 0, 0,  0, 'h0123);
    step("prog_enter",   0, 0, 0, 0, 1, 'h000, 3, 3, 49, 0, 0,  0, 'h0123);
    step("key4",         0, 0, 0, 0, 0, 'h010, 3, 3, 49, 0, 0,  0, 'h0123);
    step("key_multi",    0, 0, 0, 0, 0, 'h003, 3, 3, 49, 0, 0,  0, 'h0123);
    step("prog_tick",    0, 1, 1, 1, 0, 'h000, 3, 3, 49, 0, 0,  0, 'h0123);
    step("key0",         0, 0, 0, 0, 0, 'h001, 3, 3, 49, 0, 0,  0, 'h0123);
    step("key9",         0, 0, 0, 0, 0, 'h200, 3, 3, 49, 0, 0,  0, 'h0123);
    step("key2_write",   0, 0, 0, 0, 0, 'h004, 0, 3, 0,  1, 1,  1, 'h4092);
    step("we_drop",      0, 0, 0, 0, 0, 'h000, 0, 3, 0,  1, 0,  0, 'h4092);
    step("arm_prog_ign", 0, 0, 0, 0, 1, 'h020, 0, 3, 0,  1, 0,  0, 'h4092);
    step("err1",         0, 0, 0, 1, 0, 'h000, 0, 2, 0,  1, 1,  0, 'h4092);
    step("err1_idle",    0, 0, 0, 0, 0, 'h000, 0, 2, 0,  1, 0,  0, 'h4092);
    step("err2",         0, 0, 0, 1, 0, 'h000, 0, 1, 0,  1, 1,  0, 'h4092);
    step("both_lock",    0, 0, 1, 1, 0, 'h000, 2, 0, 30, 0, 1,  0, 'h4092);
    step("lock_ignore",  0, 0, 1, 1, 1, 'h001, 2, 0, 30, 0, 0,  0, 'h4092);
    for (int i = 1; i <= 30; i++) begin
      step($sformatf("lock_t%0d", i), 0, 1, 0, 0, 0, 'h000,
           (i < 30) ? 2 : 0, (i < 30) ? 0 : 3, 30 - i,
           (i < 30) ? 0 : 1, (i < 30) ? 0 : 1, 0, 'h4092);
      if (i % 7 == 0)
        step($sformatf("lock_gap%0d", i), 0, 0, 0, 0, 0, 'h000,
             2, 0, 30 - i, 0, 0, 0, 'h4092);
    end
    step("rearm_idle",   0, 0, 0, 0, 0, 'h000, 0, 3, 0,  1, 0,  0, 'h4092);
    step("correct2",     0, 0, 1, 0, 0, 'h000, 1, 3, 50, 0, 1,  0, 'h4092);
    for (int i = 1; i <= 49; i++)
      step($sformatf("unl_t%0d", i), 0, 1, 0, 0, 0, 'h000, 1, 3, 50 - i, 0, 0, 0, 'h4092);
    step("prog_vs_exp",  0, 1, 0, 0, 1, 'h000, 3, 3, 1,  0, 0,  0, 'h4092);
    step("key_0x011",    0, 0, 0, 0, 0, 'h011, 3, 3, 1,  0, 0,  0, 'h4092);
    step("key3",         0, 0, 0, 0, 0, 'h008, 3, 3, 1,  0, 0,  0, 'h4092);
    step("abort",        0, 0, 0, 0, 1, 'h000, 0, 3, -1, 1, -1, 0, 'h4092);
    step("abort_idle",   0, 0, 0, 0, 0, 'h000, 0, 3, -1, 1, 0,  0, 'h4092);
    step("correct3",     0, 0, 1, 0, 0, 'h000, 1, 3, 50, 0, 1,  0, 'h4092);
    step("prog2",        0, 0, 0, 0, 1, 'h000, 3, 3, 50, 0, 0,  0, 'h4092);
    step("p2_key1",      0, 0, 0, 0, 0, 'h002, 3, 3, 50, 0, 0,  0, 'h4092);
    step("p2_key5",      0, 0, 0, 0, 0, 'h020, 3, 3, 50, 0, 0,  0, 'h4092);
    step("rst_mid_prog", 1, 0, 0, 0, 0, 'h040, 0, 3, 0,  1, 1,  0, 'h0123);
    step("post_rst",     0, 0, 0, 0, 0, 'h000, 0, 3, 0,  1, 0,  0, 'h0123);
    step("correct4",     0, 0, 1, 0, 0, 'h000, 1, 3, 50, 0, 1,  0, 'h0123);
    step("prog3",        0, 0, 0, 0, 1, 'h000, 3, 3, 50, 0, 0,  0, 'h0123);
    step("p3_key7",      0, 0, 0, 0, 0, 'h080, 3, 3, 50, 0, 0,  0, 'h0123);
    step("p3_key6",      0, 0, 0, 0, 0, 'h040, 3, 3, 50, 0, 0,  0, 'h0123);
    step("p3_key8",      0, 0, 0, 0, 0, 'h100, 3, 3, 50, 0, 0,  0, 'h0123);
    step("p3_key0_wr",   0, 0, 0, 0, 0, 'h001, 0, 3, 0,  1, 1,  1, 'h7680);
    step("p3_done",      0, 0, 0, 0, 0, 'h000, 0, 3, 0,  1, 0,  0, 'h7680);

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
